complex_accumulator: RTL
========================

Name: complex_accumulator

Overview:
- Downstream stage of the 8x8 complex multiplier; consumes its 16-bit signed Re/Im products plus valid strobe.
- Sums LEN consecutive accepted products per frame into saturating ACC_W-bit accumulators (complex dot product / correlator tap sum).
- Emits one registered frame result with a one-cycle valid pulse and a per-frame overflow flag.
- Result feeds the correlator output register bank.

Parameters:
- IN_W, 16, width of signed Re/Im inputs (multiplier product width)
- ACC_W, 20, width of signed accumulators and outputs; legal range ACC_W > IN_W
- LEN, 8, products per frame; legal range 2..255
- EDGE_MODE, 1, 0 = every cycle with valid_in high is a sample; 1 = only a 0->1 transition of valid_in is a sample (upstream holds valid across several cycles)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- re_in  input  IN_W  signed real product
- im_in  input  IN_W  signed imaginary product
- valid_in  input  1  sample strobe; bit 0 of the multiplier's valid output
- clear  input  1  abort current frame, discard partial sums
- re_acc_out  output  ACC_W  signed real frame sum
- im_acc_out  output  ACC_W  signed imaginary frame sum
- valid_out  output  1  one-cycle pulse, result registers updated
- ovf_out  output  1  saturation occurred in the frame just emitted
- busy  output  1  high while a partial frame is held (cnt != 0)

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset, while rst is high at a clk edge: re_acc_out=0, im_acc_out=0, valid_out=0, ovf_out=0, busy=0, internal accumulators=0, cnt=0, ovf_sticky=0, valid_d=0.
  - Reset mid-frame discards the partial sum; no valid_out pulse.
- Sample qualification:
  - EDGE_MODE=0: sample = valid_in.
  - EDGE_MODE=1: sample = valid_in & ~valid_d, where valid_d is valid_in registered.
  - valid_d also updates during clear; it is forced to 0 only by reset.
- State is implied by cnt (0..LEN-1):
  - IDLE: cnt==0, accumulators 0.
  - ACCUM: 0<cnt<LEN.
- Accumulation: sign-extend input to ACC_W+1 bits, add to accumulator, then saturate.
  - Positive overflow saturates to 2^(ACC_W-1)-1; negative to -2^(ACC_W-1).
  - Re and Im saturate independently.
  - Any saturation sets ovf_sticky.
  - A saturated accumulator keeps accumulating from its clamped value.
- Non-final sample (cnt<LEN-1): accumulators <= sat(acc+in); cnt++.
- Final sample (cnt==LEN-1), at that same edge:
  - re_acc_out/im_acc_out <= sat(acc+in).
  - ovf_out <= ovf_sticky | sat_this_sample.
  - valid_out <= 1.
  - accumulators <= 0; cnt <= 0; ovf_sticky <= 0.
- Latency: valid_out is high in the cycle immediately after the edge capturing the LEN-th sample. It is low in every other cycle.
- Outputs hold their last values between pulses.
- Back-to-back frames: a sample in the cycle after a final sample is sample 0 of the next frame. There is no dead cycle.
- clear (rst low):
  - accumulators, cnt, ovf_sticky <= 0.
  - Any sample in the same cycle is discarded; clear wins, including over a final sample (no pulse).
  - Output registers are unchanged; valid_out <= 0.
- No backpressure: downstream must capture on valid_out.
- busy = (cnt != 0), registered.

Test Plan:
- LEN=4, EDGE_MODE=0: four consecutive cycles (re,im)=(100,-50) -> valid_out pulse 1 cycle after 4th sample; re_acc_out=400, im_acc_out=-200, ovf_out=0; busy 1 during samples 2-4, 0 after.
- LEN=4, EDGE_MODE=1: valid_in held high 3 cycles per sample, 4 pulses with re=(1,2,3,4), im=(-1,-2,-3,-4) -> exactly one valid_out; re=10, im=-10.
- ACC_W=17, LEN=4: re_in=32767 x4, im_in=-32768 x4 -> re_acc_out=65535, im_acc_out=-65536, ovf_out=1. Next frame of (1,1) x4 -> (4,4), ovf_out=0.
- LEN=4: 2 samples of (10,10), clear with a simultaneous sample, then 4 samples of (5,-5) -> one pulse with (20,-20); outputs unchanged at the clear; busy 0 after clear.
- LEN=4: 8 consecutive samples re=1..8, im=0 -> pulses carrying 10 and then 26, each one cycle after the 4th and 8th samples; no gap.
- rst asserted after 3 of 4 samples, then 4 samples of (7,7) -> all outputs 0 during reset; single pulse (28,28); no pulse from the aborted frame.

Source files
------------

// File: rtl/complex_accumulator.sv
// complex_accumulator: sums LEN accepted complex products per frame into
// saturating ACC_W-bit Re/Im accumulators and emits one registered result
// per frame with a one-cycle valid pulse and a per-frame overflow flag.
module complex_accumulator #(
  parameter int IN_W      = 16,
  parameter int ACC_W     = 20,
  parameter int LEN       = 8,
  parameter int EDGE_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  re_in,
  input  logic signed [IN_W-1:0]  im_in,
  input  logic                    valid_in,
  input  logic                    clear,
  output logic signed [ACC_W-1:0] re_acc_out,
  output logic signed [ACC_W-1:0] im_acc_out,
  output logic                    valid_out,
  output logic                    ovf_out,
  output logic                    busy
);

  // cnt holds 0..LEN-1; LEN is at most 255 so 8 bits always suffice
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  // Clamp an ACC_W+1 bit sum to ACC_W bits; the two top bits differ only on overflow
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] x);
    if (x[ACC_W] != x[ACC_W-1]) sat = {x[ACC_W], {(ACC_W-1){~x[ACC_W]}}};
    else                        sat = x[ACC_W-1:0];
  endfunction

  // Flags that sat() would clamp this sum
  function automatic logic sat_hit(input logic signed [ACC_W:0] x);
    sat_hit = (x[ACC_W] != x[ACC_W-1]);
  endfunction

  logic signed [ACC_W-1:0] re_acc_q, re_acc_d;
  logic signed [ACC_W-1:0] im_acc_q, im_acc_d;
  logic signed [ACC_W-1:0] re_out_q, re_out_d;
  logic signed [ACC_W-1:0] im_out_q, im_out_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sticky_q, sticky_d;
  logic                    valid_d_q, valid_d_d;
  logic                    vout_q, vout_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, busy_d;

  logic                    sample;
  logic signed [ACC_W:0]   re_sum, im_sum;
  logic signed [ACC_W-1:0] re_sat, im_sat;
  logic                    sat_now;

  // Sample qualification, widened add and saturation of the running sums
  always_comb begin
    if (EDGE_MODE != 0) sample = valid_in & ~valid_d_q;
    else                sample = valid_in;
    re_sum  = $signed({re_acc_q[ACC_W-1], re_acc_q})
            + $signed({{(ACC_W+1-IN_W){re_in[IN_W-1]}}, re_in});
    im_sum  = $signed({im_acc_q[ACC_W-1], im_acc_q})
            + $signed({{(ACC_W+1-IN_W){im_in[IN_W-1]}}, im_in});
    re_sat  = sat(re_sum);
    im_sat  = sat(im_sum);
    sat_now = sat_hit(re_sum) | sat_hit(im_sum);
  end

  // Frame control: clear beats any sample, the final sample publishes the result
  always_comb begin
    re_acc_d  = re_acc_q;
    im_acc_d  = im_acc_q;
    re_out_d  = re_out_q;
    im_out_d  = im_out_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    ovf_d     = ovf_q;
    vout_d    = 1'b0;
    valid_d_d = valid_in;
    if (clear) begin
      re_acc_d = '0;
      im_acc_d = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (sample) begin
      if (cnt_q == LAST) begin
        re_out_d = re_sat;
        im_out_d = im_sat;
        ovf_d    = sticky_q | sat_now;
        vout_d   = 1'b1;
        re_acc_d = '0;
        im_acc_d = '0;
        cnt_d    = '0;
        sticky_d = 1'b0;
      end else begin
        re_acc_d = re_sat;
        im_acc_d = im_sat;
        cnt_d    = cnt_q + 8'd1;
        sticky_d = sticky_q | sat_now;
      end
    end
    busy_d = (cnt_d != '0);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      re_acc_q  <= '0;
      im_acc_q  <= '0;
      re_out_q  <= '0;
      im_out_q  <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      valid_d_q <= 1'b0;
      vout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      re_acc_q  <= re_acc_d;
      im_acc_q  <= im_acc_d;
      re_out_q  <= re_out_d;
      im_out_q  <= im_out_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      valid_d_q <= valid_d_d;
      vout_q    <= vout_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

  assign re_acc_out = re_out_q;
  assign im_acc_out = im_out_q;
  assign valid_out  = vout_q;
  assign ovf_out    = ovf_q;
  assign busy       = busy_q;

endmodule
